// File: rtl/pulse1_controller.sv
// Pulse channel 1 register file and sequencing front end.
// Holds NR10..NR14 and decodes them into the channel-1 field outputs. Turns an
// NR14 trigger write into a clean one-cycle trigger pulse. Runs the 512 Hz frame
// sequencer that produces the length, sweep and envelope strobes.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   power_en              APU master enable; low holds the block cleared
//   wr_en/wr_addr/wr_data register write port (0..4 = NR10..NR14)
//   rd_en/rd_addr/rd_data registered, masked register read port
//   clk_256/128/64        one-cycle frame-sequencer strobes
//   sweep_period..freq    decoded channel fields
//   length_enable         NR14[6]
//   trigger               one-cycle trigger pulse
module pulse1_controller #(
    parameter int unsigned CLK_DIV = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_en,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        clk_256,
    output logic        clk_128,
    output logic        clk_64,
    output logic [2:0]  sweep_period,
    output logic        negate,
    output logic [2:0]  shift,
    output logic [1:0]  duty_cycle,
    output logic [5:0]  length_load,
    output logic [3:0]  starting_volume,
    output logic        env_add,
    output logic [2:0]  period,
    output logic [10:0] freq,
    output logic        length_enable,
    output logic        trigger
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [6:0]      nr10_q, nr10_d;
    logic [7:0]      nr11_q, nr11_d;
    logic [7:0]      nr12_q, nr12_d;
    logic [7:0]      nr13_q, nr13_d;
    logic [3:0]      nr14_q, nr14_d;   // {length_enable, freq[10:8]}
    logic [7:0]      rd_data_q, rd_data_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      step_q, step_d;
    logic [2:0]      strobe_q, strobe_d; // {clk_256, clk_128, clk_64}
    logic [2:0]      defer_q, defer_d;   // strobe set pushed back by a trigger
    logic            trig_pend_q, trig_pend_d;
    logic            trigger_q, trigger_d;

    logic            wr_ok, trig_wr, trig_fire, wrap;
    logic [2:0]      set_now;

    function automatic logic [2:0] step_strobes(input logic [2:0] s);
        step_strobes = {~s[0], (s == 3'd2) || (s == 3'd6), s == 3'd7};
    endfunction

    function automatic logic [7:0] rd_mux(input logic [2:0] a, input logic [6:0] r10,
                                          input logic [7:0] r11, input logic [7:0] r12,
                                          input logic len);
        case (a)
            3'd0:    rd_mux = {1'b1, r10};
            3'd1:    rd_mux = {r11[7:6], 6'h3F};
            3'd2:    rd_mux = r12;
            3'd4:    rd_mux = {1'b1, len, 6'h3F};
            default: rd_mux = 8'hFF;
        endcase
    endfunction

    always_comb begin
        nr10_d      = nr10_q;
        nr11_d      = nr11_q;
        nr12_d      = nr12_q;
        nr13_d      = nr13_q;
        nr14_d      = nr14_q;
        rd_data_d   = rd_data_q;
        defer_d     = 3'b000;
        strobe_d    = 3'b000;

        wr_ok = power_en && wr_en;
        if (wr_ok) begin
            case (wr_addr)
                3'd0:    nr10_d = wr_data[6:0];
                3'd1:    nr11_d = wr_data;
                3'd2:    nr12_d = wr_data;
                3'd3:    nr13_d = wr_data;
                3'd4:    nr14_d = {wr_data[6], wr_data[2:0]};
                default: ;
            endcase
        end

        // Reads see the pre-write register contents.
        if (rd_en) begin
            if (power_en) begin
                rd_data_d = rd_mux(rd_addr, nr10_q, nr11_q, nr12_q, nr14_q[3]);
            end else begin
                rd_data_d = rd_mux(rd_addr, 7'd0, 8'd0, 8'd0, 1'b0);
            end
        end

        // A pulse only fires after a low cycle, so back-to-back triggers
        // come out as 1,0,1; the single pending flag merges extra writes.
        trig_wr     = wr_ok && (wr_addr == 3'd4) && wr_data[7];
        trig_fire   = trig_pend_q && !trigger_q;
        trigger_d   = trig_fire;
        trig_pend_d = (trig_pend_q && !trig_fire) || trig_wr;

        wrap    = (div_q == DivLast);
        div_d   = wrap ? '0 : div_q + 1'b1;
        step_d  = wrap ? step_q + 3'd1 : step_q;
        set_now = defer_q | (wrap ? step_strobes(step_q + 3'd1) : 3'b000);

        // Never let a strobe share a cycle with trigger; the divider is not
        // touched, so later strobes keep their nominal timing.
        if (trigger_d && (set_now != 3'b000)) begin
            defer_d = set_now;
        end else begin
            strobe_d = set_now;
        end

        if (!power_en) begin
            nr10_d      = '0;
            nr11_d      = '0;
            nr12_d      = '0;
            nr13_d      = '0;
            nr14_d      = '0;
            div_d       = '0;
            step_d      = '0;
            strobe_d    = '0;
            defer_d     = '0;
            trig_pend_d = 1'b0;
            trigger_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nr10_q      <= '0;
            nr11_q      <= '0;
            nr12_q      <= '0;
            nr13_q      <= '0;
            nr14_q      <= '0;
            rd_data_q   <= '0;
            div_q       <= '0;
            step_q      <= '0;
            strobe_q    <= '0;
            defer_q     <= '0;
            trig_pend_q <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            nr10_q      <= nr10_d;
            nr11_q      <= nr11_d;
            nr12_q      <= nr12_d;
            nr13_q      <= nr13_d;
            nr14_q      <= nr14_d;
            rd_data_q   <= rd_data_d;
            div_q       <= div_d;
            step_q      <= step_d;
            strobe_q    <= strobe_d;
            defer_q     <= defer_d;
            trig_pend_q <= trig_pend_d;
            trigger_q   <= trigger_d;
        end
    end

    assign rd_data         = rd_data_q;
    assign clk_256         = strobe_q[2];
    assign clk_128         = strobe_q[1];
    assign clk_64          = strobe_q[0];
    assign sweep_period    = nr10_q[6:4];
    assign negate          = nr10_q[3];
    assign shift           = nr10_q[2:0];
    assign duty_cycle      = nr11_q[7:6];
    assign length_load     = nr11_q[5:0];
    assign starting_volume = nr12_q[7:4];
    assign env_add         = nr12_q[3];
    assign period          = nr12_q[2:0];
    assign freq            = {nr14_q[2:0], nr13_q};
    assign length_enable   = nr14_q[3];
    assign trigger         = trigger_q;

endmodule

// File: tb/tb_pulse1_controller.sv
// Self-checking bench for pulse1_controller with CLK_DIV = 4.
module tb_pulse1_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        power_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = 3'd0;
    logic [7:0]  rd_data;
    logic        clk_256, clk_128, clk_64;
    logic [2:0]  sweep_period;
    logic        negate;
    logic [2:0]  shift;
    logic [1:0]  duty_cycle;
    logic [5:0]  length_load;
    logic [3:0]  starting_volume;
    logic        env_add;
    logic [2:0]  period;
    logic [10:0] freq;
    logic        length_enable;
    logic        trigger;

    int checks = 0;
    int errors = 0;

    pulse1_controller #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .power_en(power_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clk_256(clk_256), .clk_128(clk_128), .clk_64(clk_64),
        .sweep_period(sweep_period), .negate(negate), .shift(shift),
        .duty_cycle(duty_cycle), .length_load(length_load),
        .starting_volume(starting_volume), .env_add(env_add), .period(period),
        .freq(freq), .length_enable(length_enable), .trigger(trigger)
    );

    always #5 clk = ~clk;

    logic [34:0] fields_act;
    logic [2:0]  strobes;
    assign fields_act = {sweep_period, negate, shift, duty_cycle, length_load,
                         starting_volume, env_add, period, freq, length_enable};
    assign strobes = {clk_256, clk_128, clk_64};

    function automatic logic [34:0] fx(input logic [2:0] sp, input logic ng, input logic [2:0] sh,
                                       input logic [1:0] du, input logic [5:0] ll,
                                       input logic [3:0] sv, input logic ea, input logic [2:0] pe,
                                       input logic [10:0] fr, input logic le);
        fx = {sp, ng, sh, du, ll, sv, ea, pe, fr, le};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [7:0] exp, input string name);
        rd_en = 1'b1; rd_addr = a;
        cycle();
        rd_en = 1'b0;
        check(name, 64'(rd_data), 64'(exp));
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [34:0] exp;
    } wvec_t;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] exp;
    } rvec_t;

    wvec_t      wv [6];
    rvec_t      rv [8];
    logic [2:0] step_exp [8];

    initial begin
        step_exp[0] = 3'b100; step_exp[1] = 3'b000; step_exp[2] = 3'b110; step_exp[3] = 3'b000;
        step_exp[4] = 3'b100; step_exp[5] = 3'b000; step_exp[6] = 3'b110; step_exp[7] = 3'b001;

        wv[0] = '{3'd0, 8'h5B, fx(3'd5, 1'b1, 3'd3, 2'd0, 6'd0, 4'd0, 1'b0, 3'd0, 11'h000, 1'b0)};
        wv[1] = '{3'd1, 8'hC7, fx(3'd5, 1'b1, 3'd3, 2'd3, 6'd7, 4'd0, 1'b0, 3'd0, 11'h000, 1'b0)};
        wv[2] = '{3'd2, 8'hA9, fx(3'd5, 1'b1, 3'd3, 2'd3, 6'd7, 4'd10, 1'b1, 3'd1, 11'h000, 1'b0)};
        wv[3] = '{3'd3, 8'h34, fx(3'd5, 1'b1, 3'd3, 2'd3, 6'd7, 4'd10, 1'b1, 3'd1, 11'h034, 1'b0)};
        wv[4] = '{3'd5, 8'hFF, fx(3'd5, 1'b1, 3'd3, 2'd3, 6'd7, 4'd10, 1'b1, 3'd1, 11'h034, 1'b0)};
        wv[5] = '{3'd4, 8'h45, fx(3'd5, 1'b1, 3'd3, 2'd3, 6'd7, 4'd10, 1'b1, 3'd1, 11'h534, 1'b1)};

        rv[0] = '{3'd0, 8'hDB}; rv[1] = '{3'd1, 8'hFF}; rv[2] = '{3'd2, 8'hA9};
        rv[3] = '{3'd3, 8'hFF}; rv[4] = '{3'd4, 8'hFF}; rv[5] = '{3'd5, 8'hFF};
        rv[6] = '{3'd6, 8'hFF}; rv[7] = '{3'd7, 8'hFF};

        // Reset state.
        @(negedge clk);
        do_reset();
        check("reset_fields", 64'(fields_act), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_strobes", 64'(strobes), 64'd0);
        check("reset_trigger", 64'(trigger), 64'd0);

        // Frame sequencer: wrap every 4 edges, first wrap enters step 1.
        for (int k = 1; k <= 64; k++) begin
            logic [2:0] e;
            cycle();
            e = (k % 4 == 0) ? step_exp[(k / 4) % 8] : 3'b000;
            check($sformatf("seq_k%0d", k), 64'(strobes), 64'(e));
        end

        // Field decode after each write.
        foreach (wv[i]) begin
            write(wv[i].addr, wv[i].data);
            check($sformatf("fields_w%0d", i), 64'(fields_act), 64'(wv[i].exp));
        end
        cycle();
        check("no_trig_without_bit7", 64'(trigger), 64'd0);

        // Same-cycle read and write of NR12 returns the old value.
        rd_en = 1'b1; rd_addr = 3'd2;
        write(3'd2, 8'h00);
        rd_en = 1'b0;
        check("rd_wr_same_old", 64'(rd_data), 64'hA9);
        check("rd_wr_same_field", 64'(starting_volume), 64'd0);
        write(3'd2, 8'hA9);

        // Single trigger: write at edge N, pulse only after edge N+1.
        write(3'd4, 8'hC5);
        check("trig1_freq", 64'(freq), 64'h534);
        check("trig1_len", 64'(length_enable), 64'd1);
        check("trig1_n", 64'(trigger), 64'd0);
        cycle(); check("trig1_n1", 64'(trigger), 64'd1);
        cycle(); check("trig1_n2", 64'(trigger), 64'd0);
        cycle(); check("trig1_n3", 64'(trigger), 64'd0);

        // Back-to-back triggers plus a third merged into the queue.
        write(3'd4, 8'hC5); check("trig2_a", 64'(trigger), 64'd0);
        write(3'd4, 8'hC5); check("trig2_b", 64'(trigger), 64'd1);
        write(3'd4, 8'hC5); check("trig2_c", 64'(trigger), 64'd0);
        cycle(); check("trig2_d", 64'(trigger), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(); check($sformatf("trig2_tail%0d", i), 64'(trigger), 64'd0);
        end

        // Read-back of every address, then hold when rd_en is low.
        foreach (rv[i]) read_check(rv[i].addr, rv[i].exp, $sformatf("read_a%0d", rv[i].addr));
        read_check(3'd0, 8'hDB, "read_a0_again");
        cycle();
        check("read_hold", 64'(rd_data), 64'hDB);

        // Trigger lands on the step-2 strobe: strobes slide one cycle.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            logic [2:0] e;
            wr_en = (k == 7); wr_addr = 3'd4; wr_data = 8'hC5;
            cycle();
            wr_en = 1'b0;
            e = (k == 9) ? 3'b110 : ((k == 16) ? 3'b100 : 3'b000);
            check($sformatf("coll_trig_k%0d", k), 64'(trigger), 64'(k == 8));
            check($sformatf("coll_strb_k%0d", k), 64'(strobes), 64'(e));
        end

        // Power down cancels a pending trigger and clears fields.
        write(3'd2, 8'hA9);
        write(3'd4, 8'hC5);
        power_en = 1'b0;
        cycle();
        check("pwr_trig_cancel", 64'(trigger), 64'd0);
        check("pwr_fields", 64'(fields_act), 64'd0);
        read_check(3'd2, 8'h00, "pwr_read_nr12");
        read_check(3'd0, 8'h80, "pwr_read_nr10");
        write(3'd2, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("pwr_strobes%0d", i), 64'(strobes), 64'd0);
        end
        power_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("pwr_on_trig%0d", i), 64'(trigger), 64'd0);
        end
        read_check(3'd2, 8'h00, "pwr_write_ignored");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
